// File: rtl/stopwatch_display_scan_pkg.sv
// Shared segment encodings and scan FSM states for the stopwatch display path.
package stopwatch_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Active-high {g,f,e,d,c,b,a} patterns
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Bundle between the stopwatch counter chain (master) and the display scanner (slave).
interface stopwatch_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] digits_bcd;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output en, digits_bcd, dp_mask,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  en, digits_bcd, dp_mask,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decode; codes 10..15 show a dash.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_bcd <= 4'd9) o_seg = SEG_DIGIT[i_bcd];
    end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 7-segment scanner with per-frame digit snapshot and blank gaps between digits.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros (digit 0 always shown).
module stopwatch_display_scan
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 8,
    parameter int SEG_ACTIVE_LOW = 1
)(
    input  logic                     clk,
    input  logic                     reset,
    stopwatch_display_scan_if.slave  bus
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int PW   = $clog2(MAXC);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] SHOW_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          POL        = (SEG_ACTIVE_LOW != 0);

    scan_state_t           r_state, w_nxt_state;
    logic [PW-1:0]         r_presc, w_nxt_presc;
    logic [IW-1:0]         r_idx,   w_nxt_idx;
    logic [DW-1:0]         r_snap,  w_nxt_snap;
    logic [NUM_DIGITS-1:0] r_dp_snap, w_nxt_dp_snap;
    logic                  w_take;

    logic [6:0]            r_seg, w_seg;
    logic                  r_dp,  w_dp;
    logic [NUM_DIGITS-1:0] r_an,  w_an;
    logic                  r_frame_done, w_frame_done;

    logic [3:0]            w_cur_bcd;
    seg_t                  w_dec;
    logic                  w_cur_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_blank, w_nxt_blank, w_lz_mask;

    // A digit is blank when it and every more significant digit are zero
    always_comb begin
        logic run;
        run       = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run          = run && (bus.digits_bcd[4*i +: 4] == 4'd0);
            w_lz_mask[i] = run;
        end
    end

    assign w_nxt_blank = w_take ? w_lz_mask : r_blank;
    assign w_cur_blank = w_nxt_blank[w_nxt_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_blank <= '0;
        else       r_blank <= w_nxt_blank;
    end
`else
    assign w_cur_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_idx        <= '0;
            r_snap       <= '0;
            r_dp_snap    <= '0;
            r_seg        <= {7{POL}};
            r_dp         <= POL;
            r_an         <= {NUM_DIGITS{POL}};
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_presc      <= w_nxt_presc;
            r_idx        <= w_nxt_idx;
            r_snap       <= w_nxt_snap;
            r_dp_snap    <= w_nxt_dp_snap;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_an         <= w_an;
            r_frame_done <= w_frame_done;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_presc = r_presc + PW'(1);
        w_nxt_idx   = r_idx;
        w_take      = 1'b0;
        if (!bus.en) begin
            w_nxt_state = IDLE;
            w_nxt_presc = '0;
            w_nxt_idx   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt_state = BLANK;
                    w_nxt_presc = '0;
                    w_nxt_idx   = '0;
                    w_take      = 1'b1;
                end
                BLANK: begin
                    if (r_presc == BLANK_LAST) begin
                        w_nxt_state = SHOW;
                        w_nxt_presc = '0;
                    end
                end
                SHOW: begin
                    if (r_presc == SHOW_LAST) begin
                        w_nxt_state = BLANK;
                        w_nxt_presc = '0;
                        if (r_idx == IDX_LAST) begin
                            w_nxt_idx = '0;
                            w_take    = 1'b1;
                        end else begin
                            w_nxt_idx = r_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    w_nxt_state = IDLE;
                    w_nxt_presc = '0;
                    w_nxt_idx   = '0;
                end
            endcase
        end
        w_nxt_snap    = w_take ? bus.digits_bcd : r_snap;
        w_nxt_dp_snap = w_take ? bus.dp_mask    : r_dp_snap;
    end

    assign w_cur_bcd = w_nxt_snap[{w_nxt_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd (w_cur_bcd),
        .o_seg (w_dec)
    );

    // Outputs are derived from next-cycle state so they land on the same edge
    always_comb begin
        w_seg        = SEG_OFF;
        w_dp         = 1'b0;
        w_an         = '0;
        w_frame_done = 1'b0;
        if (w_nxt_state == SHOW) begin
            w_seg        = w_cur_blank ? SEG_OFF : w_dec;
            w_dp         = w_nxt_dp_snap[w_nxt_idx];
            w_an         = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_nxt_idx;
            w_frame_done = (w_nxt_presc == SHOW_LAST) && (w_nxt_idx == IDX_LAST);
        end
        w_seg = w_seg ^ {7{POL}};
        w_dp  = w_dp  ^ POL;
        w_an  = w_an  ^ {NUM_DIGITS{POL}};
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Randomized bench for stopwatch_display_scan against a frame-position reference model.
module tb_stopwatch_display_scan;

    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int BC  = 1;
    localparam int DPD = RD + BC;
    localparam int FR  = ND * DPD;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_display_scan_if #(.NUM_DIGITS(ND)) bus();

    stopwatch_display_scan #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h40;
        endcase
    endfunction

    // Model: running flag plus cycles elapsed since the scan started
    bit          m_run;
    int          m_c;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 1'b0; m_c = 0; m_snap = '0; m_dp = '0;
        end else if (!bus.en) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1; m_c = 0; m_snap = bus.digits_bcd; m_dp = bus.dp_mask;
        end else begin
            m_c++;
            if (m_c % FR == 0) begin
                m_snap = bus.digits_bcd; m_dp = bus.dp_mask;
            end
        end
    end

    function automatic void model_out(output logic [6:0] s, output logic d,
                                      output logic [3:0] a, output logic f);
        int p, dg, ph;
        logic [3:0] v;
        bit blank;
        s = 7'h7F; d = 1'b1; a = 4'hF; f = 1'b0;
        if (m_run) begin
            p  = m_c % FR;
            dg = p / DPD;
            ph = p % DPD;
            if (ph >= BC) begin
                v     = 4'((m_snap >> (4*dg)) & 16'hF);
                blank = LZB && (dg >= 1) && ((m_snap >> (4*dg)) == 16'h0);
                a     = ~(4'b0001 << dg);
                s     = blank ? 7'h7F : ~seg_of(v);
                d     = ~m_dp[dg];
            end
            f = (p == FR - 1);
        end
    endfunction

    always @(negedge clk) begin
        logic [6:0] es; logic ed; logic [3:0] ea; logic ef;
        if (cmp_on && !reset) begin
            model_out(es, ed, ea, ef);
            chk("model_seg", 32'(bus.seg), 32'(es));
            chk("model_dp", 32'(bus.dp), 32'(ed));
            chk("model_an", 32'(bus.an), 32'(ea));
            chk("model_frame_done", 32'(bus.frame_done), 32'(ef));
        end
    end

    task automatic wait_an(input logic [3:0] v, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.an === v) begin ok = 1'b1; break; end
        end
        chk("wait_an_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_fd(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin n = i; break; end
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; bus.en = 1'b0; bus.digits_bcd = '0; bus.dp_mask = '0;
        #3;
        chk("reset_seg", 32'(bus.seg), 32'h7F);
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_fd", 32'(bus.frame_done), 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0; cmp_on = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_seg", 32'(bus.seg), 32'h7F);
        chk("idle_an", 32'(bus.an), 32'hF);

        bus.digits_bcd = 16'h1234; bus.en = 1'b1;
        wait_an(4'hE, 60); chk("d0_seg_4", 32'(bus.seg), 32'h19);
        wait_an(4'hD, 60); chk("d1_seg_3", 32'(bus.seg), 32'h30);
        wait_an(4'hB, 60); chk("d2_seg_2", 32'(bus.seg), 32'h24);
        wait_an(4'h7, 60); chk("d3_seg_1", 32'(bus.seg), 32'h79);
        wait_fd(40, n); chk("fd_seen", 32'(n > 0), 32'd1);
        wait_fd(40, n); chk("fd_period", 32'(n), 32'd20);

        wait_an(4'hE, 60);
        bus.digits_bcd = 16'h5678;
        wait_an(4'h7, 60); chk("midframe_old_d3", 32'(bus.seg), 32'h79);
        wait_an(4'hE, 60); chk("newframe_d0_8", 32'(bus.seg), 32'h00);

        bus.digits_bcd = 16'h00AF;
        wait_fd(40, n);
        wait_an(4'hE, 60); chk("dash_d0", 32'(bus.seg), 32'h3F);
        wait_an(4'hD, 60); chk("dash_d1", 32'(bus.seg), 32'h3F);
        wait_an(4'hB, 60); chk("zero_d2", 32'(bus.seg), 32'h40);
        wait_an(4'h7, 60); chk("zero_d3", 32'(bus.seg), 32'h40);

        wait_an(4'hB, 60);
        bus.en = 1'b0;
        @(negedge clk); chk("en_off_an", 32'(bus.an), 32'hF);
        repeat (3) @(negedge clk);
        bus.digits_bcd = 16'h1234; bus.en = 1'b1;
        @(negedge clk); chk("restart_blank", 32'(bus.an), 32'hF);
        @(negedge clk); chk("restart_d0_an", 32'(bus.an), 32'hE);
        chk("restart_d0_seg", 32'(bus.seg), 32'h19);
        wait_an(4'hD, 60);
        #2 reset = 1'b1;
        #1 chk("async_rst_an", 32'(bus.an), 32'hF);
        chk("async_rst_seg", 32'(bus.seg), 32'h7F);
        @(negedge clk); reset = 1'b0;

        bus.en = 1'b0;
        @(negedge clk);
        bus.digits_bcd = 16'h0050; bus.dp_mask = 4'b0100; bus.en = 1'b1;
        wait_an(4'hE, 60); chk("lz_d0", 32'(bus.seg), 32'h40);
        wait_an(4'hD, 60); chk("lz_d1_5", 32'(bus.seg), 32'h12);
        wait_an(4'hB, 60); chk("lz_d2", 32'(bus.seg), LZB ? 32'h7F : 32'h40);
        chk("lz_d2_dp", 32'(bus.dp), 32'h0);
        wait_an(4'h7, 60); chk("lz_d3", 32'(bus.seg), LZB ? 32'h7F : 32'h40);
        chk("lz_d3_dp", 32'(bus.dp), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(149) == 0) bus.en = ~bus.en;
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: bus.digits_bcd = 16'($urandom);
                    1: bus.digits_bcd = 16'($urandom) & 16'h000F;
                    2: bus.digits_bcd = 16'($urandom) & 16'h00FF;
                    default: bus.digits_bcd = 16'($urandom) & 16'h0FFF;
                endcase
                bus.dp_mask = 4'($urandom);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
